// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single memory slave.
// Live requests are forwarded combinationally; losers are parked in per-master pend registers.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_rd,
  input  logic        m0_we,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_rd,
  input  logic        m1_we,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_rd,
  output logic        s_we,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic        grant,
  output logic        proto_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_n;

  logic             last_grant;
  logic [1:0]       pend;
  logic [1:0]       pend_we;
  logic [1:0][31:0] pend_a;
  logic [1:0][31:0] pend_d;
  logic [1:0][31:0] spo_q;
  logic             proto_err_q;

  logic [1:0][31:0] m_a_v, m_d_v, spo_v;
  logic [1:0]       req, m_we_v, outstanding, live, cand, cap, ready_v;
  logic             do_grant, gnt, g_live, g_we, owner, cur_we, done;
  logic [31:0]      g_a, g_d;

  // Arbitration and next-state decode
  always_comb begin
    m_a_v  = {m1_a, m0_a};
    m_d_v  = {m1_d, m0_d};
    req    = {m1_rd | m1_we, m0_rd | m0_we};
    m_we_v = {m1_we, m0_we};

    for (int unsigned i = 0; i < 2; i++) begin
      outstanding[i] = pend[i] | ((state == BUSY) && (last_grant == i[0]));
    end

    // a request from a master that already has an access in flight is dropped
    live     = req & ~outstanding;
    cand     = (state == IDLE) ? (live | pend) : 2'b00;
    do_grant = |cand;
    gnt      = (&cand) ? ~last_grant : cand[1];

    g_live = live[gnt];
    g_we   = g_live ? m_we_v[gnt] : pend_we[gnt];
    g_a    = g_live ? m_a_v[gnt]  : pend_a[gnt];
    g_d    = g_live ? m_d_v[gnt]  : pend_d[gnt];

    owner  = (state == BUSY) ? last_grant : gnt;
    cur_we = (state == BUSY) ? pend_we[last_grant] : g_we;
    done   = (do_grant || (state == BUSY)) && s_ready;

    cap = live;
    if (do_grant) begin
      cap[gnt] = 1'b0;
    end

    state_n = state;
    if (do_grant && !s_ready) begin
      state_n = BUSY;
    end else if ((state == BUSY) && s_ready) begin
      state_n = IDLE;
    end
  end

  // Slave and master outputs; reset forces the quiescent values
  always_comb begin
    s_a   = do_grant ? g_a : pend_a[last_grant];
    s_d   = do_grant ? g_d : pend_d[last_grant];
    s_rd  = do_grant & ~g_we & ~rst;
    s_we  = do_grant &  g_we & ~rst;
    grant = rst | (do_grant ? gnt : last_grant);

    for (int unsigned i = 0; i < 2; i++) begin
      ready_v[i] = rst | (done && (owner == i[0])) | ~(live[i] | outstanding[i]);
      if (rst) begin
        spo_v[i] = '0;
      end else if (done && (owner == i[0])) begin
        spo_v[i] = s_spo;
      end else begin
        spo_v[i] = spo_q[i];
      end
    end

    m0_ready  = ready_v[0];
    m1_ready  = ready_v[1];
    m0_spo    = spo_v[0];
    m1_spo    = spo_v[1];
    proto_err = proto_err_q & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      pend        <= '0;
      pend_we     <= '0;
      pend_a      <= '0;
      pend_d      <= '0;
      spo_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (do_grant) begin
        last_grant <= gnt;
      end
      proto_err_q <= proto_err_q | (|(req & outstanding));

      for (int unsigned i = 0; i < 2; i++) begin
        if (cap[i]) begin
          pend[i]    <= 1'b1;
          pend_a[i]  <= m_a_v[i];
          pend_d[i]  <= m_d_v[i];
          pend_we[i] <= m_we_v[i];
        end else if (do_grant && (gnt == i[0])) begin
          // pend registers double as the hold registers while BUSY
          pend[i]    <= 1'b0;
          pend_a[i]  <= g_a;
          pend_d[i]  <= g_d;
          pend_we[i] <= g_we;
        end

        if (done && (owner == i[0]) && !cur_we) begin
          spo_q[i] <= s_spo;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the two masters and the slave.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m0_a = '0, m0_d = '0, m1_a = '0, m1_d = '0;
  logic        m0_rd = 1'b0, m0_we = 1'b0, m1_rd = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_spo, m1_spo, s_a, s_d;
  logic [31:0] s_spo = '0;
  logic        s_ready = 1'b0;
  logic        m0_ready, m1_ready, s_rd, s_we, grant, proto_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_a(m0_a), .m0_d(m0_d), .m0_rd(m0_rd), .m0_we(m0_we),
    .m0_spo(m0_spo), .m0_ready(m0_ready),
    .m1_a(m1_a), .m1_d(m1_d), .m1_rd(m1_rd), .m1_we(m1_we),
    .m1_spo(m1_spo), .m1_ready(m1_ready),
    .s_a(s_a), .s_d(s_d), .s_rd(s_rd), .s_we(s_we),
    .s_spo(s_spo), .s_ready(s_ready),
    .grant(grant), .proto_err(proto_err)
  );

  // Transaction-level model: who owns the slave, who is waiting, what each master last read.
  int          owner = -1;
  int          last = 1;
  bit          wait_v[2] = '{0, 0};
  bit          wait_we[2];
  logic [31:0] wait_a[2], wait_d[2];
  logic [31:0] held[2] = '{32'h0, 32'h0};
  bit          own_we;
  logic [31:0] own_a, own_d;
  bit          perr = 0;
  int          foreign[2] = '{0, 0};

  bit          exp_srd, exp_swe, exp_chk_s, exp_grant, exp_perr, fair_bad;
  bit          exp_rdy[2];
  logic [31:0] exp_sa, exp_sd;
  logic [31:0] exp_spo[2];

  function automatic bit engaged(int i);
    return wait_v[i] || (owner == i);
  endfunction

  function automatic void model_eval();
    bit          rq[2], acc[2], mw[2];
    logic [31:0] ma[2], md[2], a, d;
    int          g, fin;
    bit          we;
    ma[0] = m0_a; md[0] = m0_d; mw[0] = m0_we; rq[0] = m0_rd | m0_we;
    ma[1] = m1_a; md[1] = m1_d; mw[1] = m1_we; rq[1] = m1_rd | m1_we;
    exp_chk_s = 0; exp_srd = 0; exp_swe = 0; fair_bad = 0;
    a = '0; d = '0;
    if (rst) begin
      exp_rdy = '{1, 1}; exp_spo = '{32'h0, 32'h0}; exp_grant = 1; exp_perr = 0;
      owner = -1; last = 1; wait_v = '{0, 0}; held = '{32'h0, 32'h0};
      perr = 0; foreign = '{0, 0};
      return;
    end
    exp_perr = perr;
    for (int i = 0; i < 2; i++) begin
      if (rq[i] && engaged(i)) perr = 1;
      acc[i] = rq[i] && !engaged(i);
    end
    exp_grant = (last == 1);
    fin = -1;
    we = 0;
    if (owner < 0) begin
      g = -1;
      if ((acc[0] || wait_v[0]) && (acc[1] || wait_v[1])) g = 1 - last;
      else if (acc[0] || wait_v[0]) g = 0;
      else if (acc[1] || wait_v[1]) g = 1;
      if (g >= 0) begin
        if (acc[g]) begin
          a = ma[g]; d = md[g]; we = mw[g]; acc[g] = 0;
        end else begin
          a = wait_a[g]; d = wait_d[g]; we = wait_we[g]; wait_v[g] = 0;
        end
        if (foreign[g] > 1) fair_bad = 1;
        foreign[g] = 0;
        if (acc[1-g] || wait_v[1-g]) foreign[1-g]++;
        exp_chk_s = 1; exp_sa = a; exp_sd = d; exp_swe = we; exp_srd = !we;
        exp_grant = (g == 1);
        last = g;
        if (s_ready) fin = g;
        else begin
          owner = g; own_a = a; own_d = d; own_we = we;
        end
      end
    end else begin
      exp_chk_s = 1; exp_sa = own_a; exp_sd = own_d; exp_grant = (owner == 1);
      we = own_we;
      if (s_ready) begin
        fin = owner; owner = -1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        wait_v[i] = 1; wait_a[i] = ma[i]; wait_d[i] = md[i]; wait_we[i] = mw[i];
      end
    end
    for (int i = 0; i < 2; i++) begin
      exp_rdy[i] = (fin == i) || !engaged(i);
      exp_spo[i] = (fin == i) ? s_spo : held[i];
    end
    if (fin >= 0 && !we) held[fin] = s_spo;
  endfunction

  // Drive one cycle at the falling edge, let the combinational paths settle, advance the model.
  task automatic step(input bit r0, w0, input logic [31:0] a0, d0,
                      input bit r1, w1, input logic [31:0] a1, d1,
                      input bit sr, input logic [31:0] sp, input bit rs);
    @(negedge clk);
    m0_rd = r0; m0_we = w0; m0_a = a0; m0_d = d0;
    m1_rd = r1; m1_we = w1; m1_a = a1; m1_d = d1;
    s_ready = sr; s_spo = sp; rst = rs;
    #2;
    model_eval();
  endtask

  task automatic idle(input bit sr, input logic [31:0] sp);
    step(0, 0, '0, '0, 0, 0, '0, '0, sr, sp, 0);
  endtask

  task automatic do_reset();
    step(0, 0, '0, '0, 0, 0, '0, '0, 0, '0, 1);
  endtask

  task automatic test_reset();
    step(1, 0, 32'h11, '0, 0, 1, 32'h22, 32'h33, 1, 32'h55, 1);
    nvec++; if (s_rd !== 1'b0 || s_we !== 1'b0) begin nerr++; $display("FAIL reset_s_req: rd=%0b we=%0b want 0 0", s_rd, s_we); end
    nvec++; if (m0_ready !== 1'b1 || m1_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: %0b %0b want 1 1", m0_ready, m1_ready); end
    nvec++; if (grant !== 1'b1) begin nerr++; $display("FAIL reset_grant: %0b want 1", grant); end
    nvec++; if (proto_err !== 1'b0) begin nerr++; $display("FAIL reset_proto_err: %0b want 0", proto_err); end
    idle(0, 32'h1234);
    nvec++; if (m0_spo !== 32'h0 || m1_spo !== 32'h0) begin nerr++; $display("FAIL reset_spo: %h %h want 0 0", m0_spo, m1_spo); end
    nvec++; if (grant !== 1'b1 || m0_ready !== 1'b1 || s_rd !== 1'b0) begin nerr++; $display("FAIL post_reset_idle: grant=%0b rdy0=%0b s_rd=%0b want 1 1 0", grant, m0_ready, s_rd); end
  endtask

  task automatic test_same_cycle_read();
    do_reset();
    step(1, 0, 32'hF000_0000, '0, 0, 0, '0, '0, 1, 32'h1300_0000, 0);
    nvec++; if (s_rd !== 1'b1 || s_we !== 1'b0) begin nerr++; $display("FAIL scr_s_req: rd=%0b we=%0b want 1 0", s_rd, s_we); end
    nvec++; if (s_a !== 32'hF000_0000) begin nerr++; $display("FAIL scr_s_a: %h want f0000000", s_a); end
    nvec++; if (m0_ready !== 1'b1 || grant !== 1'b0) begin nerr++; $display("FAIL scr_ready_grant: rdy=%0b grant=%0b want 1 0", m0_ready, grant); end
    nvec++; if (m0_spo !== 32'h1300_0000) begin nerr++; $display("FAIL scr_spo: %h want 13000000", m0_spo); end
    idle(1, 32'h7777_7777);
    nvec++; if (m0_spo !== 32'h1300_0000 || s_rd !== 1'b0) begin nerr++; $display("FAIL scr_held: spo=%h s_rd=%0b want 13000000 0", m0_spo, s_rd); end
  endtask

  task automatic test_write_wait();
    step(0, 0, '0, '0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, '0, 0);
    nvec++; if (s_we !== 1'b1 || s_rd !== 1'b0) begin nerr++; $display("FAIL ww_issue: we=%0b rd=%0b want 1 0", s_we, s_rd); end
    nvec++; if (s_a !== 32'h100 || s_d !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL ww_addr_data: %h %h want 100 deadbeef", s_a, s_d); end
    nvec++; if (m1_ready !== 1'b0 || grant !== 1'b1) begin nerr++; $display("FAIL ww_grant_cycle: rdy=%0b grant=%0b want 0 1", m1_ready, grant); end
    for (int k = 0; k < 2; k++) begin
      idle(0, 32'hFFFF_0000);
      nvec++; if (s_we !== 1'b0 || s_a !== 32'h100 || s_d !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL ww_hold: we=%0b a=%h d=%h want 0 100 deadbeef", s_we, s_a, s_d); end
      nvec++; if (m1_ready !== 1'b0 || grant !== 1'b1) begin nerr++; $display("FAIL ww_busy: rdy=%0b grant=%0b want 0 1", m1_ready, grant); end
    end
    idle(1, 32'h9999_9999);
    nvec++; if (m1_ready !== 1'b1) begin nerr++; $display("FAIL ww_done: rdy=%0b want 1", m1_ready); end
    idle(1, 32'h5);
    nvec++; if (m1_spo !== 32'h0 || m1_ready !== 1'b1 || s_we !== 1'b0) begin nerr++; $display("FAIL ww_no_spo_update: spo=%h rdy=%0b we=%0b want 0 1 0", m1_spo, m1_ready, s_we); end
  endtask

  task automatic test_tie();
    do_reset();
    step(1, 0, 32'h10, '0, 1, 0, 32'h20, '0, 0, '0, 0);
    nvec++; if (grant !== 1'b0 || s_rd !== 1'b1 || s_a !== 32'h10) begin nerr++; $display("FAIL tie_first: grant=%0b rd=%0b a=%h want 0 1 10", grant, s_rd, s_a); end
    nvec++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin nerr++; $display("FAIL tie_ready: %0b %0b want 0 0", m0_ready, m1_ready); end
    idle(0, '0);
    nvec++; if (s_rd !== 1'b0 || s_a !== 32'h10 || m0_ready !== 1'b0) begin nerr++; $display("FAIL tie_busy0: rd=%0b a=%h rdy=%0b want 0 10 0", s_rd, s_a, m0_ready); end
    idle(1, 32'hAAAA_0000);
    nvec++; if (m0_ready !== 1'b1 || m0_spo !== 32'hAAAA_0000 || m1_ready !== 1'b0) begin nerr++; $display("FAIL tie_done0: rdy0=%0b spo0=%h rdy1=%0b want 1 aaaa0000 0", m0_ready, m0_spo, m1_ready); end
    idle(0, '0);
    nvec++; if (s_rd !== 1'b1 || s_a !== 32'h20 || grant !== 1'b1 || m1_ready !== 1'b0) begin nerr++; $display("FAIL tie_issue1: rd=%0b a=%h grant=%0b rdy=%0b want 1 20 1 0", s_rd, s_a, grant, m1_ready); end
    idle(0, '0);
    nvec++; if (s_rd !== 1'b0 || m1_ready !== 1'b0) begin nerr++; $display("FAIL tie_busy1: rd=%0b rdy=%0b want 0 0", s_rd, m1_ready); end
    idle(1, 32'hBBBB_0000);
    nvec++; if (m1_ready !== 1'b1 || m1_spo !== 32'hBBBB_0000) begin nerr++; $display("FAIL tie_done1: rdy=%0b spo=%h want 1 bbbb0000", m1_ready, m1_spo); end
    idle(0, '0);
    nvec++; if (m1_spo !== 32'hBBBB_0000 || m0_spo !== 32'hAAAA_0000) begin nerr++; $display("FAIL tie_held: %h %h want aaaa0000 bbbb0000", m0_spo, m1_spo); end
  endtask

  task automatic test_round_robin();
    int ngr = 0;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      step(!engaged(0), 0, $urandom, '0, !engaged(1), 0, $urandom, '0,
           1'($urandom_range(0, 1)), $urandom, 0);
      if (s_rd || s_we) begin
        nvec++; if (grant !== 1'(ngr % 2)) begin nerr++; $display("FAIL rr_alternate: grant #%0d=%0b want %0d", ngr, grant, ngr % 2); end
        ngr++;
      end
      nvec++; if (fair_bad) begin nerr++; $display("FAIL rr_fairness: waited for more than one foreign access, cycle %0d", c); end
    end
    nvec++; if (ngr < 4) begin nerr++; $display("FAIL rr_grant_count: %0d want >=4", ngr); end
  endtask

  task automatic test_proto();
    int cnt = 0;
    do_reset();
    step(1, 0, 32'h30, '0, 0, 0, '0, '0, 0, '0, 0);
    nvec++; if (s_rd !== 1'b1 || grant !== 1'b0) begin nerr++; $display("FAIL pe_m0_issue: rd=%0b grant=%0b want 1 0", s_rd, grant); end
    step(0, 0, '0, '0, 1, 0, 32'h40, '0, 0, '0, 0);
    nvec++; if (m1_ready !== 1'b0 || s_rd !== 1'b0 || proto_err !== 1'b0) begin nerr++; $display("FAIL pe_m1_pend: rdy=%0b rd=%0b err=%0b want 0 0 0", m1_ready, s_rd, proto_err); end
    step(0, 0, '0, '0, 1, 0, 32'h44, '0, 0, '0, 0);
    nvec++; if (m1_ready !== 1'b0 || proto_err !== 1'b0) begin nerr++; $display("FAIL pe_second_req: rdy=%0b err=%0b want 0 0", m1_ready, proto_err); end
    for (int k = 0; k < 6; k++) begin
      idle(1, $urandom);
      nvec++; if (proto_err !== 1'b1) begin nerr++; $display("FAIL pe_sticky: err=%0b want 1 (cycle %0d)", proto_err, k); end
      if (s_rd && grant) begin
        cnt++;
        nvec++; if (s_a !== 32'h40) begin nerr++; $display("FAIL pe_m1_addr: %h want 40", s_a); end
      end
    end
    nvec++; if (cnt !== 1) begin nerr++; $display("FAIL pe_m1_access_count: %0d want 1", cnt); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    step(1, 0, 32'h50, '0, 0, 0, '0, '0, 0, '0, 0);
    step(0, 0, '0, '0, 0, 0, '0, '0, 0, '0, 1);
    nvec++; if (m0_ready !== 1'b1 || m1_ready !== 1'b1 || s_rd !== 1'b0 || grant !== 1'b1) begin nerr++; $display("FAIL rb_in_reset: rdy=%0b%0b rd=%0b grant=%0b want 11 0 1", m0_ready, m1_ready, s_rd, grant); end
    for (int k = 0; k < 3; k++) begin
      idle(1, 32'hCAFE_0000);
      nvec++; if (m0_ready !== 1'b1 || m1_ready !== 1'b1 || s_rd !== 1'b0 || s_we !== 1'b0) begin nerr++; $display("FAIL rb_after: rdy=%0b%0b rd=%0b we=%0b want 11 0 0", m0_ready, m1_ready, s_rd, s_we); end
      nvec++; if (m0_spo !== 32'h0 || m1_spo !== 32'h0) begin nerr++; $display("FAIL rb_spo: %h %h want 0 0", m0_spo, m1_spo); end
    end
  endtask

  task automatic test_random();
    bit r[2], w[2];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        r[i] = 0; w[i] = 0;
        if (!engaged(i) && $urandom_range(0, 2) == 0) begin
          w[i] = 1'($urandom_range(0, 1));
          r[i] = !w[i] || ($urandom_range(0, 3) == 0);
        end
      end
      step(r[0], w[0], $urandom, $urandom, r[1], w[1], $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom, 0);
      nvec++; if (s_rd !== exp_srd || s_we !== exp_swe) begin nerr++; $display("FAIL rnd_s_req c%0d: rd=%0b we=%0b want %0b %0b", c, s_rd, s_we, exp_srd, exp_swe); end
      if (exp_chk_s) begin
        nvec++; if (s_a !== exp_sa || s_d !== exp_sd) begin nerr++; $display("FAIL rnd_s_ad c%0d: %h %h want %h %h", c, s_a, s_d, exp_sa, exp_sd); end
      end
      nvec++; if (m0_ready !== exp_rdy[0] || m1_ready !== exp_rdy[1]) begin nerr++; $display("FAIL rnd_ready c%0d: %0b %0b want %0b %0b", c, m0_ready, m1_ready, exp_rdy[0], exp_rdy[1]); end
      nvec++; if (m0_spo !== exp_spo[0] || m1_spo !== exp_spo[1]) begin nerr++; $display("FAIL rnd_spo c%0d: %h %h want %h %h", c, m0_spo, m1_spo, exp_spo[0], exp_spo[1]); end
      nvec++; if (grant !== exp_grant) begin nerr++; $display("FAIL rnd_grant c%0d: %0b want %0b", c, grant, exp_grant); end
      nvec++; if (proto_err !== exp_perr) begin nerr++; $display("FAIL rnd_proto_err c%0d: %0b want %0b", c, proto_err, exp_perr); end
      nvec++; if (fair_bad) begin nerr++; $display("FAIL rnd_fairness c%0d: waited for more than one foreign access", c); end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle_read();
    test_write_wait();
    test_tie();
    test_round_robin();
    test_proto();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have ports: clk, input, 1, clock; all state updates on the rising edge.
REQ-002 The block SHALL have ports: rst, input, 1, reset; synchronous, active-high.
REQ-003 The block SHALL have ports: m0_a/m1_a, input, 32, master address; valid only in the request cycle.
REQ-004 The block SHALL have ports: m0_d/m1_d, input, 32, master write data; valid only in the request cycle.
REQ-005 The block SHALL have ports: m0_rd/m1_rd, input, 1, one-cycle read request pulse.
REQ-006 The block SHALL have ports: m0_we/m1_we, input, 1, one-cycle write request pulse.
REQ-007 The block SHALL have ports: m0_spo/m1_spo, output, 32, read data to master.
REQ-008 The block SHALL have ports: m0_ready/m1_ready, output, 1, high = no outstanding access for that master.
REQ-009 The block SHALL have ports: s_a, s_d, output, 32 each, slave address and write data.
REQ-010 The block SHALL have ports: s_rd, s_we, output, 1 each, slave request pulses.
REQ-011 The block SHALL have ports: s_spo, input, 32, slave read data.
REQ-012 The block SHALL have ports: s_ready, input, 1, slave done/idle.
REQ-013 The block SHALL have ports: grant, output, 1, master currently owning the slave (0 = m0).
REQ-014 The block SHALL have ports: proto_err, output, 1, sticky protocol-violation flag.

Function
REQ-015 Request rule: a request SHALL be rd or we high for one cycle; rd and we both high SHALL be treated as a write (s_rd not asserted).
REQ-016 States SHALL be IDLE, BUSY; registers SHALL be last_grant, and per-master pend, pend_a, pend_d, pend_we, spo_q.
REQ-017 Candidates in IDLE SHALL be live requests plus pending requests.
REQ-018 When both masters are candidates in IDLE, the master != last_grant SHALL win (round-robin); a single candidate SHALL always win.
REQ-019 Live grant in IDLE SHALL pass the master's a/d/rd/we to s_* combinationally in the same cycle (zero added latency).
REQ-020 Pending grant in IDLE SHALL drive s_a/s_d from pend registers and pulse s_rd/s_we for exactly one cycle, then clear pend.
REQ-021 Same-cycle completion: if s_ready = 1 in the grant cycle, the access SHALL complete in that cycle, with m_ready = 1 and m_spo = s_spo combinationally; spo_q SHALL be updated, and the state SHALL remain IDLE.
REQ-022 Otherwise the state SHALL go to BUSY, latching address/data into the granted master's pend registers.
REQ-023 In BUSY, s_a/s_d SHALL be held from registers with s_rd = s_we = 0.
REQ-024 In BUSY, the granted master's ready SHALL stay 0 until s_ready = 1.
REQ-025 In the BUSY cycle where s_ready = 1, m_ready SHALL be 1, m_spo SHALL equal s_spo, spo_q SHALL be updated, and the next state SHALL be IDLE.
REQ-026 last_grant SHALL update on every grant.
REQ-027 A losing or non-granted master's request SHALL be captured into its pend registers; its ready SHALL be 0 from the request cycle until its own completion.
REQ-028 A request arriving in the BUSY completion cycle SHALL be pended and issued in the next IDLE cycle (one bubble).
REQ-029 An idle master SHALL see ready = 1 and spo = spo_q (last read data held).
REQ-030 A new request from a master with an access outstanding SHALL be ignored and SHALL set proto_err.
REQ-031 Write completions SHALL NOT update spo_q.
REQ-032 Fairness: a requester SHALL wait for at most one other master's access before being granted.
REQ-033 grant SHALL reflect the current owner in the grant cycle and throughout BUSY, and SHALL hold last_grant in IDLE.

Reset
REQ-034 On rst, the state SHALL go to IDLE, pend SHALL be cleared, last_grant SHALL be 1 (m0 wins the first tie), and spo_q SHALL be 0.
REQ-035 On rst, outputs SHALL be: s_rd = s_we = 0, m0_ready = m1_ready = 1, proto_err = 0, grant = 1.
REQ-036 Reset mid-BUSY SHALL abandon the access; a later s_ready/s_spo SHALL NOT affect any master.

Verification
REQ-037 m0_rd, a=0xF0000000, s_ready held 1, s_spo=0x13000000 -> same-cycle s_rd=1, s_a=0xF0000000, m0_ready=1, m0_spo=0x13000000.
REQ-038 m1_we, a=0x100, d=0xDEADBEEF, s_ready low 3 cycles -> s_we one cycle, s_a/s_d held, m1_ready=0 for 3 cycles then 1.
REQ-039 m0_rd and m1_rd same cycle after reset, slave 2-cycle latency -> m0 served first; m1 s_rd issued in the IDLE cycle after m0 completes; m1_spo correct.
REQ-040 Repeated simultaneous requests from both masters -> grants alternate 0,1,0,1; neither master waits for more than one foreign access.
REQ-041 m1_rd during m0 BUSY, then m1_rd again before completion -> proto_err=1 sticky; exactly one m1 slave access is issued.
REQ-042 rst asserted during BUSY, then s_ready pulses -> m_ready=1, s_rd=s_we=0, spo_q=0; no ready glitch to either master.
